// File: rtl/x_sys_driver.sv
// ============================================================================
// Module      : x_sys_driver
// Description : Sweeps a fixed 40-entry operand set into the x_system function
//               unit and compacts every returned Z into a running signature.
//               Optional define X_SYS_DRIVER_MISR_EN selects a MISR signature;
//               otherwise the signature is an additive checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_sys_driver #(
  parameter int          SETTLE  = 4,
  parameter logic [21:0] EXP_SIG = 22'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [21:0] i_z,
  output logic [4:0]  o_x,
  output logic [1:0]  o_sel,
  output logic        o_type,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [5:0]  o_vec_idx,
  output logic        o_z_valid,
  output logic [21:0] o_z_data,
  output logic [21:0] o_sig
);

  // A settle time of zero still needs one APPLY cycle before capture.
  localparam int                 c_SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int                 c_CNT_W      = $clog2(c_SETTLE_EFF + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_SETTLE_EFF - 1);
  localparam logic [5:0]         c_LAST_IDX   = 6'd39;
  localparam logic [2:0]         c_LAST_XPOS  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_xpos;
  logic [21:0]        w_sig_next;
  logic [2:0]         w_xpos_next;
  logic               w_xpos_wrap;

  function automatic logic [4:0] x_lut(input logic [2:0] pos);
    case (pos)
      3'd0:    return 5'b11111;
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00000;
      3'd3:    return 5'b01001;
      default: return 5'b01111;
    endcase
  endfunction

`ifdef X_SYS_DRIVER_MISR_EN
  assign w_sig_next = {o_sig[20:0], o_sig[21] ^ o_sig[20]} ^ i_z;
`else
  assign w_sig_next = o_sig + i_z;
`endif

  always_comb begin
    w_xpos_wrap = (r_xpos == c_LAST_XPOS);
    w_xpos_next = w_xpos_wrap ? 3'd0 : r_xpos + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_xpos    <= '0;
      o_x       <= '0;
      o_sel     <= '0;
      o_type    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
      o_vec_idx <= '0;
      o_z_valid <= 1'b0;
      o_z_data  <= '0;
      o_sig     <= '0;
    end else begin
      o_z_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state   <= S_APPLY;
            r_cnt     <= '0;
            r_xpos    <= '0;
            o_x       <= x_lut(3'd0);
            o_sel     <= 2'd0;
            o_type    <= 1'b1;
            o_vec_idx <= '0;
            o_sig     <= '0;
            o_busy    <= 1'b1;
            o_done    <= 1'b0;
            o_pass    <= 1'b0;
          end
        end
        S_APPLY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          o_z_data  <= i_z;
          o_sig     <= w_sig_next;
          o_z_valid <= 1'b1;
          if (o_vec_idx == c_LAST_IDX) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_pass  <= (w_sig_next == EXP_SIG);
          end else begin
            r_state   <= S_APPLY;
            r_cnt     <= '0;
            o_vec_idx <= o_vec_idx + 6'd1;
            r_xpos    <= w_xpos_next;
            o_x       <= x_lut(w_xpos_next);
            // Type runs 1 then 0 within each Sel group.
            if (w_xpos_wrap) begin
              if (o_type) begin
                o_type <= 1'b0;
              end else begin
                o_type <= 1'b1;
                o_sel  <= o_sel + 2'd1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/x_sys_driver.md
X_SYS_DRIVER -- requirements
Module: x_sys_driver

Interface
REQ-001 The block SHALL provide parameter SETTLE, default 4, setting the cycles each vector is held before Z is sampled; a value of 0 SHALL behave as 1.
REQ-002 The block SHALL provide parameter EXP_SIG, default 22'h000000, the expected final signature.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request a full sweep; sampled only in IDLE or DONE.
REQ-006 Z  input  22  result bus returned by the x_system function unit.
REQ-007 X  output  5  operand driven to the function unit.
REQ-008 Sel  output  2  function select driven to the function unit.
REQ-009 type  output  1  signed/unsigned select driven to the function unit.
REQ-010 busy  output  1  high in APPLY and CAPTURE.
REQ-011 done  output  1  high in DONE, held until start or rst.
REQ-012 pass  output  1  valid while done is high; high iff sig == EXP_SIG.
REQ-013 vec_idx  output  6  index of the vector currently driven, 0..39.
REQ-014 z_valid  output  1  one-cycle pulse when z_data is updated.
REQ-015 z_data  output  22  last sampled Z.
REQ-016 sig  output  22  running signature of sampled Z values.

Function
REQ-017 The vector set SHALL hold 40 entries, ordered Sel outermost (00,01,10,11), then type (1 then 0), then X innermost (11111, 00001, 00000, 01001, 01111); vec_idx = Sel*10 + (1-type)*5 + xpos.
REQ-018 The FSM SHALL use the states IDLE, APPLY, CAPTURE and DONE.
REQ-019 IDLE/DONE with start=1: next state APPLY; vec_idx=0; vector 0 driven; settle counter=0; sig cleared to 0; done cleared.
REQ-020 APPLY: counter increments each cycle; after SETTLE cycles, next state CAPTURE.
REQ-021 CAPTURE, at the closing edge: Z latched into z_data; sig updated; z_valid=1 for the following cycle.
REQ-022 CAPTURE with vec_idx<39, at the closing edge: vec_idx+1 and its vector driven; counter cleared; state APPLY.
REQ-023 CAPTURE with vec_idx=39, at the closing edge: state DONE; X/Sel/type hold vector 39; vec_idx stays 39.
REQ-024 Each vector SHALL occupy exactly SETTLE+1 cycles; a full sweep SHALL take 40*(SETTLE+1) cycles from start acceptance to done rising.
REQ-025 start during APPLY/CAPTURE SHALL be ignored.
REQ-026 Signature arithmetic SHALL be modulo 2^22 with no saturation; carry-out SHALL be discarded.
REQ-027 pass SHALL be 0 whenever done=0.

Reset
REQ-028 rst=1 at any edge, including mid-sweep, SHALL force IDLE on the next cycle.
REQ-029 Reset values: X=0, Sel=0, type=0, vec_idx=0, counter=0, busy=0, done=0, pass=0, z_valid=0, z_data=0, sig=0.
REQ-030 rst SHALL take priority over start in the same cycle.

Configuration
REQ-031 With macro X_SYS_DRIVER_MISR_EN defined, the sig update SHALL be the MISR form: sig <= {sig[20:0], sig[21]^sig[20]} ^ Z.
REQ-032 Without X_SYS_DRIVER_MISR_EN, the sig update SHALL be the additive form: sig <= sig + Z (mod 2^22).
REQ-033 All other behaviour SHALL be identical in both builds.

Verification
REQ-034 Reset then start pulse, SETTLE=4: cycle after acceptance X=5'b11111, Sel=00, type=1, busy=1; first z_valid exactly 5 cycles later.
REQ-035 Full sweep, SETTLE=4, additive build, Z tied to 22'h000001: done rises 200 cycles after acceptance; sig=22'h000028; pass=1 with EXP_SIG=22'h000028; z_valid pulsed 40 times.
REQ-036 MISR build, Z tied to 0: sig=0 at done; pass=1 with default EXP_SIG.
REQ-037 rst asserted at vec_idx=17 mid-APPLY: next cycle all outputs at reset values; a subsequent start restarts at vec_idx=0 with sig=0.
REQ-038 start held high throughout a sweep: no restart while busy; start seen in DONE re-launches and clears done and sig.
REQ-039 SETTLE=0 build: each vector held 2 cycles; sweep length 80 cycles.
